// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : types_pkg
// Brief    : Shared datapath types plus the divider opcode/state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package types_pkg;

  localparam int XLEN = 32;

  typedef logic        [XLEN-1:0] word_t;
  typedef logic signed [XLEN-1:0] signed_word_t;

  // Divider operation selector; bit 1 picks remainder, bit 0 picks unsigned
  typedef enum logic [1:0] {
    DIV_S = 2'b00,
    DIV_U = 2'b01,
    REM_S = 2'b10,
    REM_U = 2'b11
  } divop_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } divstate_e;

  // Accept edge to out_valid for the iterative path
  localparam int DIV_LATENCY = XLEN + 1;

  function automatic logic is_signed_op(input divop_e o);
    return (o == DIV_S) || (o == REM_S);
  endfunction

  function automatic logic is_rem_op(input divop_e o);
    return (o == REM_S) || (o == REM_U);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One combinational restoring-division iteration on {rem, quo}.
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift the next dividend bit into the remainder and try to subtract.
  // The remainder is always below the divisor, so WIDTH+1 bits cannot
  // overflow and the trial MSB acts as the borrow/sign.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_i};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//            One quotient bit per cycle; divide-by-zero and signed overflow
//            finish on the accepting edge.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit
  import types_pkg::*;
#(
  parameter int WIDTH = $bits(word_t),
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  divop_e           op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  divstate_e        state_q;
  divop_e           op_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             negq_q;
  logic             negr_q;
  logic [WIDTH-1:0] result_q;

  logic             sgn_op;
  logic             sa;
  logic             sb;
  logic             div0;
  logic             ovf;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  // Classify the incoming operation and form operand magnitudes
  always_comb begin
    sgn_op  = is_signed_op(op);
    sa      = sgn_op & dividend[WIDTH-1];
    sb      = sgn_op & divisor[WIDTH-1];
    div0    = (divisor == '0);
    ovf     = sgn_op && (dividend == MIN_NEG) && (divisor == '1);
    dvd_mag = sa ? (~dividend + 1'b1) : dividend;
    dsr_mag = sb ? (~divisor + 1'b1) : divisor;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dsr_i (dsr_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  // Control FSM and datapath registers; rst beats flush, flush beats accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= DIV_S;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q <= op;
            if (div0) begin
              result_q <= is_rem_op(op) ? dividend : '1;
              state_q  <= DONE;
            end else if (ovf) begin
              result_q <= is_rem_op(op) ? '0 : MIN_NEG;
              state_q  <= DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= dvd_mag;
              dsr_q   <= dsr_mag;
              cnt_q   <= CNT_W'(WIDTH - 1);
              negq_q  <= sa ^ sb;
              negr_q  <= sa;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == '0) begin
            state_q <= FIXUP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        FIXUP: begin
          if (is_rem_op(op_q)) begin
            result_q <= negr_q ? (~rem_q + 1'b1) : rem_q;
          end else begin
            result_q <= negq_q ? (~quo_q + 1'b1) : quo_q;
          end
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Directed and corner-operand checks for div_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;
  import types_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  divop_e      op_r;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int compares = 0;
  int fails    = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op_r),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // Reference: SystemVerilog division truncates toward zero like RV32M
  function automatic logic [31:0] model(input divop_e o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (o)
      DIV_U:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM_U:   return (b == 0) ? a : a % b;
      DIV_S: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
    endcase
  endfunction

  // Present one op, wait for out_valid. lat counts edges after the accepting
  // edge (special cases finish on the accepting edge itself, so lat = 0).
  // With consume set, also take the handshake edge so the unit is IDLE again.
  task automatic run_op(input divop_e o, input logic [31:0] a, input logic [31:0] b,
                        input bit consume, output logic [31:0] res, output int lat);
    compares++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    op_r     = o;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) begin
      compares++;
      fails++;
      $display("FAIL timeout: no out_valid within 100 edges");
    end
    res = result;
    if (consume) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    compares++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    compares++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    compares++; if (result !== 32'h0)    begin fails++; $display("FAIL rst_result: got %h want 0", result); end
    compares++; if (busy !== 1'b0)       begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_unsigned;
    logic [31:0] r;
    int lat;
    run_op(DIV_U, 32'd100, 32'd7, 1'b1, r, lat);
    compares++; if (r !== 32'd14) begin fails++; $display("FAIL divu_100_7: got %h want %h", r, 32'd14); end
    compares++; if (lat !== DIV_LATENCY) begin fails++; $display("FAIL divu_latency: got %0d want %0d", lat, DIV_LATENCY); end
    compares++; if (in_ready !== 1'b1) begin fails++; $display("FAIL divu_idle_after: in_ready=%b want 1", in_ready); end
    run_op(REM_U, 32'd100, 32'd7, 1'b1, r, lat);
    compares++; if (r !== 32'd2) begin fails++; $display("FAIL remu_100_7: got %h want %h", r, 32'd2); end
  endtask

  task automatic test_signs;
    logic [31:0] r;
    int lat;
    run_op(DIV_S, 32'hFFFF_FFF9, 32'd2, 1'b1, r, lat);
    compares++; if (r !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_m7_2: got %h want FFFFFFFD", r); end
    run_op(REM_S, 32'hFFFF_FFF9, 32'd2, 1'b1, r, lat);
    compares++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rem_m7_2: got %h want FFFFFFFF", r); end
    run_op(DIV_S, 32'd7, 32'hFFFF_FFFE, 1'b1, r, lat);
    compares++; if (r !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_7_m2: got %h want FFFFFFFD", r); end
    run_op(REM_S, 32'd7, 32'hFFFF_FFFE, 1'b1, r, lat);
    compares++; if (r !== 32'd1) begin fails++; $display("FAIL rem_7_m2: got %h want 1", r); end
  endtask

  task automatic test_special;
    logic [31:0] r;
    int lat;
    run_op(DIV_U, 32'd5, 32'd0, 1'b1, r, lat);
    compares++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divu_by0: got %h want FFFFFFFF", r); end
    compares++; if (lat !== 0) begin fails++; $display("FAIL divu_by0_lat: got %0d want 0", lat); end
    run_op(REM_S, 32'hFFFF_FFFB, 32'd0, 1'b1, r, lat);
    compares++; if (r !== 32'hFFFF_FFFB) begin fails++; $display("FAIL rems_by0: got %h want FFFFFFFB", r); end
    compares++; if (lat !== 0) begin fails++; $display("FAIL rems_by0_lat: got %0d want 0", lat); end
    run_op(DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, lat);
    compares++; if (r !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf: got %h want 80000000", r); end
    compares++; if (lat !== 0) begin fails++; $display("FAIL div_ovf_lat: got %0d want 0", lat); end
    run_op(REM_S, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, lat);
    compares++; if (r !== 32'h0) begin fails++; $display("FAIL rem_ovf: got %h want 0", r); end
    compares++; if (lat !== 0) begin fails++; $display("FAIL rem_ovf_lat: got %0d want 0", lat); end
    // Unsigned ops never see signed overflow: 0x80000000 / 0xFFFFFFFF = 0
    run_op(DIV_U, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, lat);
    compares++; if (r !== 32'h0) begin fails++; $display("FAIL divu_noovf: got %h want 0", r); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    int lat;
    out_ready = 1'b0;
    run_op(DIV_U, 32'd1000, 32'd3, 1'b0, r, lat);
    compares++; if (r !== 32'd333) begin fails++; $display("FAIL bp_value: got %h want %h", r, 32'd333); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      compares++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd333) begin
        fails++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b result=%h want 1 0 %h",
                 i, out_valid, in_ready, result, 32'd333);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    compares++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    run_op(REM_U, 32'd1000, 32'd3, 1'b1, r, lat);
    compares++; if (r !== 32'd1) begin fails++; $display("FAIL bp_second: got %h want 1", r); end
  endtask

  task automatic test_flush;
    logic [31:0] r;
    int lat;
    bit seen;
    seen = 1'b0;
    op_r = DIV_U; dividend = 32'd100; divisor = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    compares++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL flush_idle: in_ready=%b busy=%b want 1 0", in_ready, busy); end
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    compares++; if (seen !== 1'b0) begin fails++; $display("FAIL flush_no_pulse: out_valid seen=%b want 0", seen); end
    // Accept presented together with flush is dropped
    op_r = DIV_U; dividend = 32'd9; divisor = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    compares++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_drops_accept: busy=%b want 0", busy); end
    run_op(DIV_U, 32'hFFFF_FFFF, 32'd3, 1'b1, r, lat);
    compares++; if (r !== 32'h5555_5555) begin fails++; $display("FAIL flush_next_op: got %h want 55555555", r); end
  endtask

  task automatic test_rst_mid;
    op_r = DIV_U; dividend = 32'd100; divisor = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    compares++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid: in_ready=%b out_valid=%b busy=%b result=%h want 1 0 0 0",
               in_ready, out_valid, busy, result);
    end
  endtask

  task automatic test_random;
    logic [31:0] corners [5];
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [31:0] exp_r;
    divop_e o;
    int lat;
    corners[0] = 32'h0;
    corners[1] = 32'h1;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      if (i % 5 == 4) b = $urandom_range(1, 20);
      o = divop_e'($urandom_range(0, 3));
      exp_r = model(o, a, b);
      run_op(o, a, b, 1'b1, r, lat);
      compares++;
      if (r !== exp_r) begin
        fails++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h: got %h want %h", i, o, a, b, r, exp_r);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_r = DIV_U; dividend = '0; divisor = '0;
    test_reset();
    test_unsigned();
    test_signs();
    test_special();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
`default_nettype wire
